pixel_scanner: RTL and testbench

//  Raster-scan source for the Mandelbrot pipeline. Walks every pixel of one frame
//  in row-major order and emits (x,y) with the matching complex coordinate (a,b).

---
 rtl/pixel_scanner.sv | 142 ++++++++++++++
 tb/tb_pixel_scanner.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_scanner.sv
// pixel_scanner: raster-scan pixel source for the Mandelbrot pipeline.
// Walks one frame row-major and presents (x, y) with the complex coordinate
// a = re_origin + x*delta, b = im_origin + y*delta, built by accumulation.
//
// Ports
//   clk_i          clock
//   rst_i          synchronous reset, active-high
//   start_i        begin a frame (pulse or level; ignored while busy)
//   delta_i        per-pixel step, signed Q10.21, latched at start
//   re_origin_i    real coordinate of x=0, latched at start
//   im_origin_i    imaginary coordinate of y=0, latched at start
//   out_ready_i    downstream accepts the current pixel
//   out_valid_o    x/y/a/b hold a valid pixel
//   x_o, y_o       pixel column / row
//   a_o, b_o       real / imaginary coordinate
//   eol_o, eof_o   last pixel of line / frame (qualified by out_valid_o)
//   busy_o         frame in progress
//   done_o         one-cycle pulse after the last pixel is accepted
module pixel_scanner #(
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480,
  parameter int unsigned W     = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [W-1:0] delta_i,
  input  logic [W-1:0] re_origin_i,
  input  logic [W-1:0] im_origin_i,
  input  logic         out_ready_i,
  output logic         out_valid_o,
  output logic [9:0]   x_o,
  output logic [9:0]   y_o,
  output logic [W-1:0] a_o,
  output logic [W-1:0] b_o,
  output logic         eol_o,
  output logic         eof_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam logic [9:0] XLast = 10'(H_RES - 1);
  localparam logic [9:0] YLast = 10'(V_RES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e       state_q, state_d;
  logic [9:0]   x_q, x_d;
  logic [9:0]   y_q, y_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] delta_q, delta_d;
  logic [W-1:0] re_q, re_d;
  logic [W-1:0] im_q, im_d;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    a_d     = a_q;
    b_d     = b_q;
    delta_d = delta_q;
    re_d    = re_q;
    im_d    = im_q;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          delta_d = delta_i;
          re_d    = re_origin_i;
          im_d    = im_origin_i;
          x_d     = '0;
          y_d     = '0;
          a_d     = re_origin_i;
          b_d     = im_origin_i;
          state_d = StRun;
        end
      end
      StRun: begin
        // Without a transfer every pixel field holds.
        if (out_ready_i) begin
          if (x_q != XLast) begin
            x_d = x_q + 10'd1;
            a_d = a_q + delta_q;
          end else if (y_q != YLast) begin
            // Reload a from the latched origin instead of accumulating, so each
            // line starts bit-exact and per-line error cannot build up.
            x_d = '0;
            a_d = re_q;
            y_d = y_q + 10'd1;
            b_d = b_q + delta_q;
          end else begin
            state_d = StDone;
          end
        end
      end
      // start in this cycle is left for the following idle cycle.
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      delta_q <= '0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      a_q     <= a_d;
      b_q     <= b_d;
      delta_q <= delta_d;
      re_q    <= re_d;
      im_q    <= im_d;
    end
  end

  always_comb begin
    out_valid_o = (state_q == StRun);
    busy_o      = (state_q == StRun);
    done_o      = (state_q == StDone);
    x_o         = x_q;
    y_o         = y_q;
    a_o         = a_q;
    b_o         = b_q;
    // Qualified with valid so flags are quiet in idle/done.
    eol_o       = out_valid_o && (x_q == XLast);
    eof_o       = eol_o && (y_q == YLast);
  end

endmodule

// File: tb/tb_pixel_scanner.sv
module tb_pixel_scanner;

  localparam int unsigned HR  = 4;
  localparam int unsigned VR  = 3;
  localparam int unsigned BHR = 1024;
  localparam int unsigned BVR = 24;
  localparam int unsigned BN  = BHR * BVR;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [31:0] a;
    logic [31:0] b;
    logic        eol;
    logic        eof;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] delta, re_o, im_o;
  logic        out_ready;
  logic        out_valid;
  logic [9:0]  x, y;
  logic [31:0] a, b;
  logic        eol, eof, busy, done;

  logic        start_b;
  logic [31:0] delta_b, re_b, im_b;
  logic        valid_b, eol_b, eof_b, busy_b, done_b;
  logic [9:0]  x_b, y_b;
  logic [31:0] a_b, b_b;

  int   n_vec  = 0;
  int   n_miss = 0;
  pix_t sb[$];
  int   n_xfer   = 0;
  int   done_cnt = 0;
  bit   pend_done = 0;
  bit   stall_v   = 0;
  pix_t held;
  bit   rand_ready = 0;

  always #5 clk = ~clk;

  pixel_scanner #(.H_RES(HR), .V_RES(VR), .W(32)) u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .delta_i     (delta),
    .re_origin_i (re_o),
    .im_origin_i (im_o),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .x_o         (x),
    .y_o         (y),
    .a_o         (a),
    .b_o         (b),
    .eol_o       (eol),
    .eof_o       (eof),
    .busy_o      (busy),
    .done_o      (done)
  );

  pixel_scanner #(.H_RES(BHR), .V_RES(BVR), .W(32)) u_big (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start_b),
    .delta_i     (delta_b),
    .re_origin_i (re_b),
    .im_origin_i (im_b),
    .out_ready_i (1'b1),
    .out_valid_o (valid_b),
    .x_o         (x_b),
    .y_o         (y_b),
    .a_o         (a_b),
    .b_o         (b_b),
    .eol_o       (eol_b),
    .eof_o       (eof_b),
    .busy_o      (busy_b),
    .done_o      (done_b)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected values come from the closed form origin + idx*delta (mod 2^32).
  task automatic push_frame(input logic [31:0] re, input logic [31:0] im,
                            input logic [31:0] d);
    pix_t p;
    for (int yy = 0; yy < int'(VR); yy++) begin
      for (int xx = 0; xx < int'(HR); xx++) begin
        p.x   = 10'(xx);
        p.y   = 10'(yy);
        p.a   = re + 32'(xx) * d;
        p.b   = im + 32'(yy) * d;
        p.eol = (xx == int'(HR) - 1);
        p.eof = p.eol && (yy == int'(VR) - 1);
        sb.push_back(p);
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops the scoreboard on every transfer, checks stall stability and
  // that done follows the eof transfer by exactly one cycle.
  always @(negedge clk) begin
    pix_t cur;
    pix_t e;
    cur = '{x: x, y: y, a: a, b: b, eol: eol, eof: eof};
    if (rst) begin
      sb.delete();
      stall_v   = 0;
      pend_done = 0;
    end else begin
      if (done || pend_done) begin
        chk("done_pulse", 64'(done), 64'(pend_done));
        if (done) done_cnt++;
      end
      pend_done = 0;
      if (stall_v) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_hold", 64'(cur), 64'(held));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_pixel", 64'({x, y}), 64'hFFFFF);
        end else begin
          e = sb.pop_front();
          chk("pix_xy", 64'({x, y}), 64'({e.x, e.y}));
          chk("pix_ab", {a, b}, {e.a, e.b});
          chk("pix_flags", 64'({eol, eof}), 64'({e.eol, e.eof}));
          if (e.eof) pend_done = 1;
        end
        n_xfer++;
        stall_v = 0;
      end else if (out_valid) begin
        stall_v = 1;
        held    = cur;
      end else begin
        stall_v = 0;
      end
    end
  end

  task automatic start_frame(input logic [31:0] re, input logic [31:0] im,
                             input logic [31:0] d);
    push_frame(re, im, d);
    @(posedge clk); #1;
    start = 1'b1;
    delta = d;
    re_o  = re;
    im_o  = im;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("first_valid_latency", 64'({out_valid, busy}), 64'b11);
  endtask

  task automatic wait_done(input string nm, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_cnt != d0) break;
    end
    chk({nm, "_done_seen"}, 64'(done_cnt - d0), 64'd1);
    chk({nm, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_xfers(input int n);
    for (int i = 0; i < 200; i++) begin
      if (n_xfer >= n) break;
      @(posedge clk); #1;
    end
    chk("reach_pixel", 64'(n_xfer >= n), 64'd1);
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {out_valid, busy, done, eol, eof, x, y, a[20:0]}, 64'd0);
    chk({nm, "_ab"}, {a, b}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int xf;
    int eofs;
    bit got_done;
    logic [9:0]  lx, ly;
    logic [31:0] la;

    rst = 1'b1; start = 1'b0; delta = '0; re_o = '0; im_o = '0; out_ready = 1'b1;
    start_b = 1'b0; delta_b = '0; re_b = '0; im_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_zero("reset_state");

    // 1: basic frame, always ready.
    start_frame(32'h0, 32'h0, 32'h0020_0000);
    wait_done("t1", 40);

    // 2: same frame under random back-pressure.
    rand_ready = 1;
    start_frame(32'h0, 32'h0, 32'h0020_0000);
    wait_done("t2", 300);
    rand_ready = 0;

    // 3: negative origin/delta; im wraps past 0x8000_0000.
    start_frame(32'hFC00_0000, 32'h8000_0000, 32'hFFF0_0000);
    wait_done("t3", 40);

    // 4: start with a new step mid-frame must be ignored.
    start_frame(32'h0010_0000, 32'h0030_0000, 32'h0001_0000);
    wait_xfers(5);
    start = 1'b1; delta = 32'h0777_0000; re_o = 32'h1234_5678; im_o = 32'h0BAD_0000;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t4", 40);

    // 5: reset at pixel 7 abandons the frame with no done pulse.
    start_frame(32'h0, 32'h0, 32'h0020_0000);
    wait_xfers(7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_zero("mid_reset");
    c = done_cnt;
    repeat (5) @(posedge clk);
    chk("no_done_after_reset", 64'(done_cnt), 64'(c));
    start_frame(32'h0040_0000, 32'h0, 32'h0008_0000);
    wait_done("t5", 40);

    // 6: large frame at full x width; the start cycle counts as cycle 1.
    re_b = 32'hC000_0000; im_b = 32'h1000_0000; delta_b = 32'h0000_1000;
    @(posedge clk); #1;
    start_b = 1'b1;
    c = 1; xf = 0; eofs = 0; got_done = 0; lx = '0; ly = '0; la = '0;
    for (int i = 0; i < int'(BN) + 10; i++) begin
      @(posedge clk); #1;
      start_b = 1'b0;
      c++;
      @(negedge clk);
      if (valid_b) begin
        xf++;
        lx = x_b; ly = y_b; la = a_b;
        if (eof_b) eofs++;
      end
      if (done_b) begin
        got_done = 1;
        break;
      end
    end
    chk("big_done_seen", 64'(got_done), 64'd1);
    chk("big_xfers", 64'(xf), 64'(BN));
    chk("big_done_cycle", 64'(c), 64'(BN + 2));
    chk("big_eof_count", 64'(eofs), 64'd1);
    chk("big_last_xy", 64'({lx, ly}), 64'({10'd1023, 10'd23}));
    chk("big_last_a", 64'(la), 64'(32'hC000_0000 + 32'd1023 * 32'h0000_1000));

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
